// File: rtl/qspi_flash_reader.sv
// Single-word quad-SPI flash reader using Fast Read Quad I/O, SCLK = clk/2.
// One request in, one little-endian 32-bit word out; no continuous-read mode.
module qspi_flash_reader #(
    parameter logic [7:0]  CMD          = 8'hEB,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    input  logic [3:0]  spi_io_in
);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StMode, StDummy, StData, StDone
    } state_e;

    localparam logic [7:0] DummyLast = 8'(2 * DUMMY_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [7:0]  r_cnt;
    logic [23:0] r_addr;
    logic [31:0] r_shift;
    logic [31:0] r_rsp_data;
    logic [31:0] w_shift_next;

    assign w_shift_next = {r_shift[27:0], spi_io_in};
    assign rsp_data     = r_rsp_data;

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        spi_cs_n     = 1'b1;
        spi_sclk     = 1'b0;
        spi_io_out   = 4'h0;
        spi_io_oe    = 4'h0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = StCmd;
            end
            StCmd: begin
                spi_cs_n   = 1'b0;
                spi_sclk   = r_cnt[0];
                spi_io_out = {3'b000, CMD[3'd7 - r_cnt[3:1]]};
                spi_io_oe  = 4'b0001;
                if (r_cnt == 8'd15) w_state_next = StAddr;
            end
            StAddr: begin
                spi_cs_n   = 1'b0;
                spi_sclk   = r_cnt[0];
                spi_io_out = r_addr[23:20];
                spi_io_oe  = 4'b1111;
                if (r_cnt == 8'd11) w_state_next = StMode;
            end
            StMode: begin
                spi_cs_n  = 1'b0;
                spi_sclk  = r_cnt[0];
                spi_io_oe = 4'b1111;
                if (r_cnt == 8'd3) w_state_next = StDummy;
            end
            StDummy: begin
                spi_cs_n = 1'b0;
                spi_sclk = r_cnt[0];
                if (r_cnt == DummyLast) w_state_next = StData;
            end
            StData: begin
                spi_cs_n = 1'b0;
                spi_sclk = r_cnt[0];
                if (r_cnt == 8'd15) w_state_next = StDone;
            end
            StDone: begin
                rsp_valid    = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_addr     <= 24'h0;
            r_shift    <= 32'h0;
            r_rsp_data <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle || r_state != w_state_next) r_cnt <= 8'd0;
            else                                              r_cnt <= r_cnt + 8'd1;
            if (r_state == StIdle && req_valid) r_addr <= req_addr;
            // Shift after the phase-1 cycle so the next nibble is stable across the SCLK period
            if (r_state == StAddr && r_cnt[0]) r_addr <= {r_addr[19:0], 4'h0};
            if (r_state == StData && r_cnt[0]) r_shift <= w_shift_next;
            if (r_state == StData && r_cnt == 8'd15) begin
                r_rsp_data <= {w_shift_next[7:0], w_shift_next[15:8],
                               w_shift_next[23:16], w_shift_next[31:24]};
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Bench for qspi_flash_reader: behavioural flash, cycle-level timing reference and
// a response scoreboard; two instances cover DUMMY_CYCLES of 4 and 6.
module tb_qspi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [23:0] req_addr;
    logic [3:0]  spi_io_in;
    logic        sel;

    logic        rdy4, rv4, cs4, sck4, rdy6, rv6, cs6, sck6;
    logic [31:0] rd4, rd6;
    logic [3:0]  io4, oe4, io6, oe6;

    always #5 clk = ~clk;

    qspi_flash_reader #(.CMD(8'hEB), .DUMMY_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rdy4),
        .req_addr(req_addr), .rsp_valid(rv4), .rsp_data(rd4), .spi_cs_n(cs4),
        .spi_sclk(sck4), .spi_io_out(io4), .spi_io_oe(oe4), .spi_io_in(spi_io_in)
    );

    qspi_flash_reader #(.CMD(8'hEB), .DUMMY_CYCLES(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rdy6),
        .req_addr(req_addr), .rsp_valid(rv6), .rsp_data(rd6), .spi_cs_n(cs6),
        .spi_sclk(sck6), .spi_io_out(io6), .spi_io_oe(oe6), .spi_io_in(spi_io_in)
    );

    logic        m_rdy, m_rv, m_cs, m_sck;
    logic [31:0] m_rd;
    logic [3:0]  m_io, m_oe;
    assign m_rdy = sel ? rdy6 : rdy4;
    assign m_rv  = sel ? rv6  : rv4;
    assign m_cs  = sel ? cs6  : cs4;
    assign m_sck = sel ? sck6 : sck4;
    assign m_rd  = sel ? rd6  : rd4;
    assign m_io  = sel ? io6  : io4;
    assign m_oe  = sel ? oe6  : oe4;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        int          acc;
    } txn_t;
    txn_t sb[$];
    int   acc_hist[$];

    int cyc_now = 0;
    always @(posedge clk) cyc_now++;

    // Timing reference and flash model, evaluated mid-cycle
    int          acc_time = 0;
    bit          in_flight = 0;
    int          nsclk = 0;
    int          rsp_cnt = 0;
    logic [7:0]  cmd_cap;
    logic [23:0] addr_cap;
    logic [7:0]  mode_cap;

    always @(negedge clk) begin
        int d, e, t, p, j;
        bit busy, exp_rdy;
        logic [3:0] exp_oe;
        logic [7:0] b;
        txn_t tx;
        d = sel ? 6 : 4;
        e = 48 + 2 * d;
        spi_io_in = 4'($urandom);
        if (!rst_n) begin
            in_flight = 0;
            nsclk     = 0;
            sb.delete();
        end else begin
            t      = cyc_now - acc_time;
            busy   = in_flight && t >= 1 && t <= e;
            p      = (t - 1) / 2;
            exp_oe = !busy ? 4'b0000 : (p < 8) ? 4'b0001 : (p < 16) ? 4'b1111 : 4'b0000;
            exp_rdy = !in_flight || t == 0 || t >= e + 2;
            chk("cs_n", {31'd0, m_cs}, {31'd0, !busy});
            chk("sclk", {31'd0, m_sck}, busy ? 32'((t - 1) % 2) : 32'd0);
            chk("oe", {28'd0, m_oe}, {28'd0, exp_oe});
            chk("ready", {31'd0, m_rdy}, {31'd0, exp_rdy});
            chk("rsp_valid", {31'd0, m_rv}, {31'd0, in_flight && t == e + 1});

            if (m_cs) nsclk = 0;
            else if (m_sck) begin
                if (nsclk < 8)       cmd_cap  = {cmd_cap[6:0], m_io[0]};
                else if (nsclk < 14) addr_cap = {addr_cap[19:0], m_io};
                else if (nsclk < 16) mode_cap = {mode_cap[3:0], m_io};
                else if (nsclk >= 16 + d && nsclk < 24 + d) begin
                    j = nsclk - 16 - d;
                    b = rd(addr_cap + 24'(j / 2));
                    spi_io_in = (j % 2 == 0) ? b[7:4] : b[3:0];
                end
                nsclk++;
            end

            if (m_rv) begin
                rsp_cnt++;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_rsp got %0d expected 1 pending", sb.size());
                end
                if (sb.size() > 0) begin
                    tx = sb.pop_front();
                    chk("rsp_data", m_rd, tx.data);
                    chk("latency", 32'(cyc_now - tx.acc), 32'(e + 1));
                    chk("cmd_bits", {24'd0, cmd_cap}, 32'h0000_00EB);
                    chk("addr_nib", {8'd0, addr_cap}, {8'd0, tx.addr});
                    chk("mode_nib", {24'd0, mode_cap}, 32'd0);
                end
            end

            if (in_flight && t >= e + 1) in_flight = 0;
            if (req_valid && exp_rdy) begin
                acc_time  = cyc_now;
                in_flight = 1;
                acc_hist.push_back(cyc_now);
                tx.addr = req_addr;
                tx.acc  = cyc_now;
                tx.data = {rd(req_addr + 24'd3), rd(req_addr + 24'd2),
                           rd(req_addr + 24'd1), rd(req_addr)};
                sb.push_back(tx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int start;
        bit got;
        start = rsp_cnt;
        got   = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            if (rsp_cnt > start) got = 1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout got no response expected one within 200 cycles", tag);
        end
    endtask

    task automatic issue(input logic [23:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        req_addr  = 24'hABCDEF;
    endtask

    initial begin
        int n;
        sel       = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 24'h0;
        spi_io_in = 4'h0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_cs_n", {31'd0, m_cs}, 32'd1);
        chk("rst_oe", {28'd0, m_oe}, 32'd0);
        chk("rst_ready", {31'd0, m_rdy}, 32'd1);
        chk("rst_rsp_data", m_rd, 32'd0);
        step();

        // Basic read with known instruction bytes
        mem[24'h000100] = 8'h13;
        mem[24'h000101] = 8'h05;
        mem[24'h000102] = 8'h00;
        mem[24'h000103] = 8'h00;
        issue(24'h000100);
        wait_rsp("t1");
        chk("t1_data", m_rd, 32'h0000_0513);
        repeat (3) step();
        chk("t1_hold", m_rd, 32'h0000_0513);

        // Request raised mid-transfer is held off until IDLE
        issue(24'h002000);
        repeat (19) step();
        req_valid = 1'b1;
        req_addr  = 24'h003333;
        chk("t3_ready_busy", {31'd0, m_rdy}, 32'd0);
        wait_rsp("t3a");
        step();
        req_valid = 1'b0;
        wait_rsp("t3b");
        repeat (2) step();

        // Back-to-back with req_valid held high, unaligned address
        n = acc_hist.size();
        req_valid = 1'b1;
        req_addr  = 24'h123457;
        wait_rsp("t2a");
        step();
        req_valid = 1'b0;
        wait_rsp("t2b");
        chk("t2_accepts", 32'(acc_hist.size() - n), 32'd2);
        if (acc_hist.size() >= n + 2)
            chk("t2_gap", 32'(acc_hist[n + 1] - acc_hist[n]), 32'd58);
        repeat (2) step();

        // Reset in the middle of the data phase
        n = rsp_cnt;
        issue(24'h000040);
        repeat (44) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_cs_n", {31'd0, m_cs}, 32'd1);
        chk("t4_oe", {28'd0, m_oe}, 32'd0);
        chk("t4_rsp_valid", {31'd0, m_rv}, 32'd0);
        chk("t4_ready", {31'd0, m_rdy}, 32'd1);
        repeat (60) step();
        chk("t4_no_rsp", 32'(rsp_cnt), 32'(n));
        issue(24'h000040);
        wait_rsp("t4b");
        repeat (2) step();

        // Longer dummy phase, top-of-array address
        sel = 1'b1;
        step();
        mem[24'hFFFFFC] = 8'hAA;
        mem[24'hFFFFFD] = 8'hBB;
        mem[24'hFFFFFE] = 8'hCC;
        mem[24'hFFFFFF] = 8'hDD;
        issue(24'hFFFFFC);
        wait_rsp("t5");
        chk("t5_data", m_rd, 32'hDDCC_BBAA);
        repeat (3) step();
        chk("t5_pending", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
